// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding and default sizing for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LDUSE = 2'd1,
    ST_MWAIT = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam int unsigned REG_BITS_DEF = 3;
  localparam int unsigned CNT_W_DEF    = 16;
  localparam int unsigned MAX_WAIT_DEF = 15;
  localparam int unsigned WAIT_W       = 8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr gives a synchronous return to zero.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (clr) begin
      q_q <= '0;
    end else if (inc && (q_q != '1)) begin
      q_q <= q_q + 1'b1;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stage enables, flush/bubble, hazard and
// memory-wait handling, halt, stall statistics and data-memory watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_BITS = REG_BITS_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] s0_rs,
  input  logic [REG_BITS-1:0] s0_rt,
  input  logic                s0_uses_rs,
  input  logic                s0_uses_rt,
  input  logic [REG_BITS-1:0] s1_rd,
  input  logic                s1_memrd,
  input  logic                br_taken,
  input  logic                imem_busy,
  input  logic                dmem_busy,
  input  logic                halt_s3,
  output logic                pc_we,
  output logic                s0_we,
  output logic                s0_flush,
  output logic                s1_we,
  output logic                s1_bubble,
  output logic                s2_we,
  output logic                s3_we,
  output logic                halted,
  output logic                err,
  output logic [CNT_W-1:0]    stall_cnt
);

  state_e            state_q, state_d;
  logic              err_q, err_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              hazard;
  logic              wd_fire;
  logic              stall_inc;
  logic              wait_inc;
  logic              wait_clr;

  assign hazard = s1_memrd && (state_q != ST_LDUSE) &&
                  ((s0_uses_rs && (s0_rs == s1_rd)) ||
                   (s0_uses_rt && (s0_rt == s1_rd)));

  assign wd_fire = (({1'b0, wait_cnt} + 9'd1) == 9'(MAX_WAIT));

  always_comb begin
    pc_we     = 1'b1;
    s0_we     = 1'b1;
    s0_flush  = 1'b0;
    s1_we     = 1'b1;
    s1_bubble = 1'b0;
    s2_we     = 1'b1;
    s3_we     = 1'b1;
    state_d   = ST_RUN;
    err_d     = err_q;
    // rst gates the enables combinationally so they drop with the async reset
    if (rst) begin
      pc_we = 1'b0; s0_we = 1'b0; s1_we = 1'b0; s2_we = 1'b0; s3_we = 1'b0;
      state_d = state_q;
    end else if (state_q == ST_HALT) begin
      pc_we = 1'b0; s0_we = 1'b0; s1_we = 1'b0; s2_we = 1'b0; s3_we = 1'b0;
      state_d = ST_HALT;
    end else if (halt_s3) begin
      pc_we = 1'b0; s0_we = 1'b0; s1_we = 1'b0; s2_we = 1'b0;
      state_d = ST_HALT;
    end else if (dmem_busy) begin
      pc_we = 1'b0; s0_we = 1'b0; s1_we = 1'b0; s2_we = 1'b0; s3_we = 1'b0;
      state_d = ST_MWAIT;
      if (wd_fire) begin
        state_d = ST_HALT;
        err_d   = 1'b1;
      end
    end else if (br_taken) begin
      s0_flush = 1'b1;
    end else if (imem_busy) begin
      pc_we    = 1'b0;
      s0_flush = 1'b1;
    end else if (hazard) begin
      pc_we     = 1'b0;
      s0_we     = 1'b0;
      s1_bubble = 1'b1;
      state_d   = ST_LDUSE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign halted    = (state_q == ST_HALT);
  assign err       = err_q;
  assign stall_inc = !pc_we && (state_q != ST_HALT);
  assign wait_inc  = dmem_busy && (state_q != ST_HALT);
  assign wait_clr  = !dmem_busy;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (stall_inc),
    .q   (stall_cnt)
  );

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (wait_clr),
    .inc (wait_inc),
    .q   (wait_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expected enables and stall counts are queued
// as each cycle's stimulus is applied and checked against the DUT mid-cycle.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] s0_rs, s0_rt, s1_rd;
  logic       s0_uses_rs, s0_uses_rt, s1_memrd;
  logic       br_taken, imem_busy, dmem_busy, halt_s3;

  logic        pc_we, s0_we, s0_flush, s1_we, s1_bubble, s2_we, s3_we, halted, err;
  logic [15:0] stall_cnt;
  logic        pc_we4, s0_we4, s0_flush4, s1_we4, s1_bubble4, s2_we4, s3_we4, halted4, err4;
  logic [3:0]  stall_cnt4;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .s0_rs(s0_rs), .s0_rt(s0_rt),
    .s0_uses_rs(s0_uses_rs), .s0_uses_rt(s0_uses_rt),
    .s1_rd(s1_rd), .s1_memrd(s1_memrd), .br_taken(br_taken),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy), .halt_s3(halt_s3),
    .pc_we(pc_we), .s0_we(s0_we), .s0_flush(s0_flush), .s1_we(s1_we),
    .s1_bubble(s1_bubble), .s2_we(s2_we), .s3_we(s3_we),
    .halted(halted), .err(err), .stall_cnt(stall_cnt)
  );

  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .s0_rs(s0_rs), .s0_rt(s0_rt),
    .s0_uses_rs(s0_uses_rs), .s0_uses_rt(s0_uses_rt),
    .s1_rd(s1_rd), .s1_memrd(s1_memrd), .br_taken(br_taken),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy), .halt_s3(halt_s3),
    .pc_we(pc_we4), .s0_we(s0_we4), .s0_flush(s0_flush4), .s1_we(s1_we4),
    .s1_bubble(s1_bubble4), .s2_we(s2_we4), .s3_we(s3_we4),
    .halted(halted4), .err(err4), .stall_cnt(stall_cnt4)
  );

  // {pc_we, s0_we, s0_flush, s1_we, s1_bubble, s2_we, s3_we, halted, err}
  localparam logic [8:0] O_ZERO = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] O_RUN  = 9'b1_1_0_1_0_1_1_0_0;
  localparam logic [8:0] O_LDU  = 9'b0_0_0_1_1_1_1_0_0;
  localparam logic [8:0] O_BR   = 9'b1_1_1_1_0_1_1_0_0;
  localparam logic [8:0] O_IMB  = 9'b0_1_1_1_0_1_1_0_0;
  localparam logic [8:0] O_DMB  = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] O_HS3  = 9'b0_0_0_0_0_0_1_0_0;
  localparam logic [8:0] O_HLT  = 9'b0_0_0_0_0_0_0_1_0;
  localparam logic [8:0] O_HLTE = 9'b0_0_0_0_0_0_0_1_1;

  typedef struct {
    string       tag;
    logic [8:0]  o;
    logic [15:0] sc;
    logic [3:0]  sc4;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [15:0] exp_stall  = '0;
  logic [3:0]  exp_stall4 = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clr_in();
    s0_rs = '0; s0_rt = '0; s1_rd = '0;
    s0_uses_rs = 1'b0; s0_uses_rt = 1'b0; s1_memrd = 1'b0;
    br_taken = 1'b0; imem_busy = 1'b0; dmem_busy = 1'b0; halt_s3 = 1'b0;
  endtask

  // Queue the expectation for the cycle whose inputs were just driven, then
  // check the DUT shortly after, well clear of the rising edge.
  task automatic expect_cycle(input string tag, input logic [8:0] o);
    exp_t e;
    e.tag = tag; e.o = o; e.sc = exp_stall; e.sc4 = exp_stall4;
    sb_q.push_back(e);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sbempty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq({e.tag, "_outs"},
               {23'd0, pc_we, s0_we, s0_flush, s1_we, s1_bubble, s2_we, s3_we, halted, err},
               {23'd0, e.o});
      check_eq({e.tag, "_stall"}, {16'd0, stall_cnt}, {16'd0, e.sc});
      check_eq({e.tag, "_stall4"}, {28'd0, stall_cnt4}, {28'd0, e.sc4});
    end
    if (!rst && !o[8] && !o[1]) begin
      if (exp_stall != 16'hFFFF) exp_stall++;
      if (exp_stall4 != 4'hF) exp_stall4++;
    end
  endtask

  task automatic cyc(input string tag, input logic [8:0] o);
    @(negedge clk);
    expect_cycle(tag, o);
  endtask

  // Reset pulse placed between edges; outputs must drop before any clock edge.
  task automatic rst_pulse(input string tag);
    @(negedge clk);
    clr_in();
    #2 rst = 1'b1;
    exp_stall = '0; exp_stall4 = '0;
    expect_cycle(tag, O_ZERO);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr_in();
    cyc("reset0", O_ZERO);
    cyc("reset1", O_ZERO);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) cyc("idle", O_RUN);

    // load-use on rs, held two cycles
    @(negedge clk);
    s1_memrd = 1'b1; s1_rd = 3'd3; s0_rs = 3'd3; s0_uses_rs = 1'b1;
    expect_cycle("lduse_rs_c1", O_LDU);
    cyc("lduse_rs_c2", O_RUN);
    @(negedge clk); clr_in(); expect_cycle("post_lduse", O_RUN);
    // load-use on rt
    @(negedge clk);
    s1_memrd = 1'b1; s1_rd = 3'd5; s0_rt = 3'd5; s0_uses_rt = 1'b1;
    expect_cycle("lduse_rt", O_LDU);
    @(negedge clk); clr_in(); expect_cycle("post_lduse_rt", O_RUN);
    // no hazard: register mismatch, then match without use flag
    @(negedge clk);
    s1_memrd = 1'b1; s1_rd = 3'd3; s0_rs = 3'd2; s0_uses_rs = 1'b1;
    expect_cycle("nohaz_mismatch", O_RUN);
    @(negedge clk); s0_rs = 3'd3; s0_uses_rs = 1'b0; s0_rt = 3'd3;
    expect_cycle("nohaz_nouse", O_RUN);
    @(negedge clk); clr_in(); s1_memrd = 1'b0; s1_rd = 3'd4; s0_rs = 3'd4; s0_uses_rs = 1'b1;
    expect_cycle("nohaz_noload", O_RUN);

    // branch beats imem_busy, then imem_busy alone
    @(negedge clk); clr_in(); br_taken = 1'b1; imem_busy = 1'b1;
    expect_cycle("br_over_imem", O_BR);
    @(negedge clk); br_taken = 1'b0;
    expect_cycle("imem_only", O_IMB);
    // branch beats load-use, dmem beats branch
    @(negedge clk); clr_in(); br_taken = 1'b1;
    s1_memrd = 1'b1; s1_rd = 3'd1; s0_rs = 3'd1; s0_uses_rs = 1'b1;
    expect_cycle("br_over_lduse", O_BR);
    @(negedge clk); clr_in(); br_taken = 1'b1; dmem_busy = 1'b1;
    expect_cycle("dmem_over_br", O_DMB);
    @(negedge clk); clr_in(); expect_cycle("resume0", O_RUN);

    // dmem_busy for three cycles
    @(negedge clk); dmem_busy = 1'b1; expect_cycle("dmem1", O_DMB);
    cyc("dmem2", O_DMB);
    cyc("dmem3", O_DMB);
    @(negedge clk); clr_in(); expect_cycle("dmem_resume", O_RUN);
    cyc("run_again", O_RUN);

    // watchdog: 15 busy cycles, then halted with err
    @(negedge clk); dmem_busy = 1'b1; expect_cycle("wd_c1", O_DMB);
    for (int i = 2; i <= 15; i++) cyc($sformatf("wd_c%0d", i), O_DMB);
    cyc("wd_fired", O_HLTE);
    @(negedge clk); clr_in(); br_taken = 1'b1; expect_cycle("wd_hold", O_HLTE);
    rst_pulse("wd_async_rst");
    cyc("wd_after_rst", O_RUN);

    // halt from writeback; inputs ignored afterwards
    @(negedge clk); halt_s3 = 1'b1; imem_busy = 1'b1; dmem_busy = 1'b1;
    expect_cycle("halt_s3", O_HS3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clr_in(); br_taken = i[0]; imem_busy = ~i[0]; s1_memrd = 1'b1;
      expect_cycle("halt_hold", O_HLT);
    end
    rst_pulse("halt_async_rst");
    cyc("halt_after_rst", O_RUN);

    // 20 fetch stalls: narrow counter sticks at 15, wide reaches 20
    @(negedge clk); imem_busy = 1'b1; expect_cycle("sat_c1", O_IMB);
    for (int i = 2; i <= 20; i++) cyc("sat_cN", O_IMB);
    @(negedge clk); clr_in(); expect_cycle("sat_final", O_RUN);
    check_eq("sat_final_wide", {16'd0, stall_cnt}, 32'd20);
    check_eq("sat_final_narrow", {28'd0, stall_cnt4}, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
